traffic_phase_ctrl: RTL and testbench

//  N-approach intersection phase controller; generalises the 2-colour single-light FSM.

---
 rtl/tl_pkg.sv | 5 +
 rtl/tl_rr_select.sv | 20 ++
 rtl/traffic_phase_ctrl.sv | 95 +++++++++
 tb/tb_traffic_phase_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: shared state and light encodings for the traffic phase controller
package tl_pkg;
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED, S_FORCED} tl_state_t;
    typedef enum logic [1:0] {L_RED = 2'b00, L_YELLOW = 2'b01, L_GREEN = 2'b10} tl_light_t;
endpackage

// File: rtl/tl_rr_select.sv
// tl_rr_select: picks the next direction with demand after active_dir, else plain rotation
module tl_rr_select #(
    parameter int N_DIR = 4
) (
    input  logic [N_DIR-1:0]         demand,
    input  logic [$clog2(N_DIR)-1:0] active_dir,
    output logic [$clog2(N_DIR)-1:0] next_dir
);
    localparam int DW = $clog2(N_DIR);
    logic [DW-1:0] idx;
    // scan farthest to nearest so the nearest requester overwrites last and wins
    always_comb begin
        idx = '0;
        next_dir = DW'((int'(active_dir) + 1) % N_DIR);
        for (int k = N_DIR; k >= 1; k--) begin
            idx = DW'((int'(active_dir) + k) % N_DIR);
            next_dir = demand[idx] ? idx : next_dir;
        end
    end
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach green/yellow/all-red phase controller with demand skip,
// hold and forced-red override; all outputs registered
module traffic_phase_ctrl
    import tl_pkg::*;
#(
    parameter int N_DIR      = 4,
    parameter int CNT_W      = 5,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick_sec,
    input  logic [N_DIR*CNT_W-1:0]   green_time,
    input  logic [N_DIR-1:0]         demand,
    input  logic                     hold,
    input  logic                     force_red,
    output logic [2*N_DIR-1:0]       light,
    output logic [$clog2(N_DIR)-1:0] active_dir,
    output logic [CNT_W-1:0]         left_time,
    output logic                     phase_start,
    output logic                     forced
);
    localparam int DW = $clog2(N_DIR);
    tl_state_t state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [DW-1:0] dir_n, next_dir;
    logic [2*N_DIR-1:0] light_n;
    logic start_n;

    tl_rr_select #(.N_DIR(N_DIR)) u_rr (
        .demand    (demand),
        .active_dir(active_dir),
        .next_dir  (next_dir)
    );

    always_comb begin
        state_n = state;
        timer_n = timer;
        dir_n = active_dir;
        start_n = 1'b0;
        light_n = '0;
        if (force_red) begin
            state_n = S_FORCED;
            timer_n = '0;
        end else if (state == S_FORCED) begin
            state_n = S_ALL_RED;
            timer_n = CNT_W'(ALLRED_SEC);
        end else if (!hold && timer == '0) begin
            // expiry takes precedence over a coincident tick
            case (state)
                S_GREEN: begin
                    state_n = S_YELLOW;
                    timer_n = CNT_W'(YELLOW_SEC);
                end
                S_YELLOW: begin
                    state_n = S_ALL_RED;
                    timer_n = CNT_W'(ALLRED_SEC);
                end
                default: begin
                    state_n = S_GREEN;
                    dir_n = next_dir;
                    timer_n = green_time[int'(next_dir)*CNT_W +: CNT_W];
                    start_n = 1'b1;
                end
            endcase
        end else if (!hold && tick_sec) begin
            timer_n = timer - 1'b1;
        end
        for (int i = 0; i < N_DIR; i++)
            light_n[2*i +: 2] = (dir_n != DW'(i)) ? L_RED :
                                (state_n == S_GREEN) ? L_GREEN :
                                (state_n == S_YELLOW) ? L_YELLOW : L_RED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_ALL_RED;
            timer <= CNT_W'(ALLRED_SEC);
            active_dir <= DW'(N_DIR - 1);
            light <= '0;
            phase_start <= 1'b0;
            forced <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            active_dir <= dir_n;
            light <= light_n;
            phase_start <= start_n;
            forced <= (state_n == S_FORCED);
        end
    end

    assign left_time = timer;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed and random scenarios checked cycle by cycle
// against a behavioural phase model
module tb_traffic_phase_ctrl;
    localparam int P_G = 0, P_Y = 1, P_R = 2, P_F = 3;
    logic clk = 1'b0, reset = 1'b1, tick_sec = 1'b0, hold = 1'b0, force_red = 1'b0;
    logic [3:0] demand = 4'b1111;
    logic [4:0] gt [4];
    logic [19:0] green_time;
    logic [7:0] light;
    logic [1:0] active_dir;
    logic [4:0] left_time;
    logic phase_start, forced;
    logic [16:0] got, exp;
    int checks = 0, errors = 0, cyc = 0;
    int m_phase, m_rem, m_dir;
    logic m_start;
    int served[$];

    assign green_time = {gt[3], gt[2], gt[1], gt[0]};
    assign got = {light, active_dir, left_time, phase_start, forced};

    always #5 clk = ~clk;

    traffic_phase_ctrl dut (
        .clk(clk), .reset(reset), .tick_sec(tick_sec), .green_time(green_time),
        .demand(demand), .hold(hold), .force_red(force_red), .light(light),
        .active_dir(active_dir), .left_time(left_time), .phase_start(phase_start),
        .forced(forced)
    );

    task automatic model_edge();
        int nd;
        bit found;
        logic [7:0] el;
        m_start = 1'b0;
        if (reset) begin
            m_phase = P_R; m_rem = 1; m_dir = 3;
        end else if (force_red) begin
            m_phase = P_F; m_rem = 0;
        end else if (m_phase == P_F) begin
            m_phase = P_R; m_rem = 1;
        end else if (!hold) begin
            if (m_rem == 0) begin
                if (m_phase == P_G) begin
                    m_phase = P_Y; m_rem = 3;
                end else if (m_phase == P_Y) begin
                    m_phase = P_R; m_rem = 1;
                end else begin
                    nd = (m_dir + 1) % 4;
                    found = 0;
                    for (int k = 1; k <= 4; k++)
                        if (!found && demand[(m_dir + k) % 4]) begin
                            nd = (m_dir + k) % 4;
                            found = 1;
                        end
                    m_phase = P_G; m_dir = nd; m_rem = int'(gt[nd]); m_start = 1'b1;
                    served.push_back(nd);
                end
            end else if (tick_sec) begin
                m_rem = m_rem - 1;
            end
        end
        el = '0;
        if (m_phase == P_G) el[2*m_dir +: 2] = 2'b10;
        else if (m_phase == P_Y) el[2*m_dir +: 2] = 2'b01;
        exp = {el, 2'(m_dir), 5'(m_rem), m_start, m_phase == P_F};
    endtask

    task automatic step();
        tick_sec = (cyc % 10 == 9);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        int want[5] = '{0, 1, 2, 3, 0};
        bit ok;
        for (int i = 0; i < 4; i++) gt[i] = 5'd5;
        demand = 4'b1111;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        checks++;
        if (got !== {8'h00, 2'd3, 5'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_values got %h need %h", got, {8'h00, 2'd3, 5'd1, 1'b0, 1'b0});
        end
        served.delete();
        repeat (500) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL rotation_model cyc %0d got %h need %h", cyc, got, exp); end
        end
        ok = served.size() >= 5;
        for (int i = 0; i < 5; i++) if (ok && served[i] != want[i]) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL serve_order got %0d serves, need 0,1,2,3,0", served.size()); end
    endtask

    task automatic test_alternate();
        bit bad = 0, ok;
        demand = 4'b0101;
        repeat (200) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL alt_settle cyc %0d got %h need %h", cyc, got, exp); end
        end
        served.delete();
        repeat (600) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL alt_model cyc %0d got %h need %h", cyc, got, exp); end
            if (light[3:2] !== 2'b00 || light[7:6] !== 2'b00) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL alt_dirs13 got lit, need 00"); end
        ok = served.size() >= 3;
        for (int i = 0; i < served.size(); i++) begin
            if (served[i] != 0 && served[i] != 2) ok = 0;
            if (i > 0 && served[i] == served[i-1]) ok = 0;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL alt_order got %0d serves, need alternating 0/2", served.size()); end
    endtask

    task automatic test_rotation();
        bit ok;
        demand = 4'b0000;
        repeat (150) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL rot_settle cyc %0d got %h need %h", cyc, got, exp); end
        end
        served.delete();
        repeat (500) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL rot_model cyc %0d got %h need %h", cyc, got, exp); end
        end
        ok = served.size() >= 4;
        for (int i = 1; i < served.size(); i++) if (served[i] != (served[i-1] + 1) % 4) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL rot_order got %0d serves, need +1 rotation", served.size()); end
    endtask

    task automatic test_zero_green();
        int g1 = 0, s1 = 0;
        bit prev_g = 0, bad = 0;
        demand = 4'b1111;
        gt[1] = 5'd0;
        repeat (500) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL zero_model cyc %0d got %h need %h", cyc, got, exp); end
            if (prev_g && light[3:2] !== 2'b01) bad = 1;
            prev_g = (light[3:2] == 2'b10);
            if (prev_g) g1++;
            if (phase_start && active_dir == 2'd1) s1++;
        end
        checks++;
        if (s1 == 0 || g1 != s1) begin errors++; $display("FAIL zero_green got %0d green clks, need %0d (serves)", g1, s1); end
        checks++;
        if (bad) begin errors++; $display("FAIL zero_to_yellow got non-yellow after 1-clk green, need 01"); end
        gt[1] = 5'd5;
    endtask

    task automatic test_force();
        bit found = 0;
        for (int i = 0; i < 1500 && !found; i++) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL force_wait cyc %0d got %h need %h", cyc, got, exp); end
            if (light[5:4] == 2'b10 && left_time == 5'd3) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL force_reach got no dir2 green at 3, need it"); end
        force_red = 1'b1;
        step();
        checks++;
        if (light !== 8'h00 || forced !== 1'b1 || left_time !== 5'd0) begin
            errors++; $display("FAIL force_enter got light %h forced %b time %0d, need 00 1 0", light, forced, left_time);
        end
        force_red = 1'b0;
        step();
        checks++;
        if (light !== 8'h00 || forced !== 1'b0 || left_time !== 5'd1 || active_dir !== 2'd2) begin
            errors++; $display("FAIL force_release got light %h forced %b time %0d dir %0d, need 00 0 1 2", light, forced, left_time, active_dir);
        end
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL force_after cyc %0d got %h need %h", cyc, got, exp); end
            found = phase_start;
        end
        checks++;
        if (!found || active_dir !== 2'd3) begin errors++; $display("FAIL force_next got dir %0d (start %b), need 3", active_dir, found); end
    endtask

    task automatic test_hold();
        bit found = 0, bad = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL hold_wait cyc %0d got %h need %h", cyc, got, exp); end
            if (light[2*active_dir +: 2] == 2'b01 && left_time == 5'd2) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL hold_reach got no yellow at 2, need it"); end
        hold = 1'b1;
        repeat (30) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL hold_model cyc %0d got %h need %h", cyc, got, exp); end
            if (left_time !== 5'd2 || light[2*active_dir +: 2] !== 2'b01) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL hold_frozen got time %0d, need 2 yellow", left_time); end
        hold = 1'b0;
        found = 0;
        for (int i = 0; i < 15 && !found; i++) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL hold_resume cyc %0d got %h need %h", cyc, got, exp); end
            found = (left_time == 5'd1);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL hold_countdown got time %0d, need 1", left_time); end
    endtask

    task automatic test_gt_change();
        bit found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL gt_wait cyc %0d got %h need %h", cyc, got, exp); end
            found = phase_start && active_dir == 2'd0;
        end
        checks++;
        if (!found || left_time !== 5'd5) begin errors++; $display("FAIL gt_first got %0d, need 5", left_time); end
        gt[0] = 5'd8;
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL gt_model cyc %0d got %h need %h", cyc, got, exp); end
            found = phase_start && active_dir == 2'd0;
        end
        checks++;
        if (!found || left_time !== 5'd8) begin errors++; $display("FAIL gt_second got %0d, need 8", left_time); end
        gt[0] = 5'd5;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL rstmid_wait cyc %0d got %h need %h", cyc, got, exp); end
            found = (light[2*active_dir +: 2] == 2'b01);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach got no yellow, need it"); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (got !== {8'h00, 2'd3, 5'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstmid_values got %h need %h", got, {8'h00, 2'd3, 5'd1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            if (cyc % 40 == 0) demand = 4'($urandom);
            if ($urandom_range(0, 99) < 2) gt[$urandom_range(0, 3)] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 3) hold = ~hold;
            force_red = ($urandom_range(0, 149) == 0);
            step(); checks++;
            if (got !== exp) begin errors++; $display("FAIL random_model cyc %0d got %h need %h", cyc, got, exp); end
        end
        hold = 1'b0;
        force_red = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_rotation();
        test_zero_green();
        test_force();
        test_hold();
        test_gt_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
